baud_tick_generator: RTL and testbench
======================================

Name: baud_tick_generator

Overview:
- Parametrised fractional baud/oversample tick generator, the successor to the fixed 11-bit integer divider.
- Produces a one-cycle oversample tick with a fractional divisor, plus a bit-rate tick and a mid-bit tick derived from a programmable oversampling ratio.
- Sits between the configuration registers and the UART transmitter/receiver; `resync` lets the receiver realign the bit phase on a detected start edge.

Parameters:
- DVSR_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor; resolution is 1/2^FRAC_W of a clock cycle.
- OSR_W, 5: width of the oversample-ratio field.
- RESET_DVSR, 650: integer divisor after reset (100 MHz, 9600 baud, x16).
- RESET_FRAC, 0: fractional divisor after reset.
- RESET_OSR, 15: oversample ratio minus 1 after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  count enable; when 0, all state holds.
- load  in  1  one-cycle pulse; captures dvsr_int/dvsr_frac/osr and restarts the divider.
- resync  in  1  one-cycle pulse; restarts the divider phase, keeps the configuration.
- dvsr_int  in  DVSR_W  integer divisor; base sample period is dvsr_int+1 cycles.
- dvsr_frac  in  FRAC_W  fractional extension numerator.
- osr  in  OSR_W  sample ticks per bit, minus 1.
- sample_tick  out  1  registered oversample tick.
- bit_tick  out  1  registered bit-rate tick, coincident with a sample_tick.
- mid_tick  out  1  registered mid-bit tick, coincident with a sample_tick.

Behaviour:
- Shadow registers dvsr_q, frac_q, osr_q are loaded only on `load`. The live inputs are ignored at all other times.
- Internal state:
  - cnt (DVSR_W bits)
  - acc (FRAC_W bits)
  - extra (1 bit)
  - sub (OSR_W bits)
- Reset (reset_n=0 at a clock edge):
  - dvsr_q=RESET_DVSR, frac_q=RESET_FRAC, osr_q=RESET_OSR.
  - cnt, acc, extra, sub = 0.
  - All outputs 0.
  - Reset overrides load, resync and en, including in the middle of a period.
- Priority: reset_n > load > resync > en.
- load cycle: capture the shadow registers, clear cnt/acc/extra/sub, outputs 0 next cycle. This applies regardless of en.
- resync cycle: clear cnt/acc/extra/sub, outputs 0 next cycle; shadow registers are unchanged. This applies regardless of en.
- en=0 (no load/resync): all state holds and outputs are 0 next cycle.
- en=1, terminal condition is cnt == dvsr_q + extra. The comparison is done in DVSR_W+1 bits, so dvsr_q = all-ones plus extra does not wrap.
- On a terminal cycle:
  - cnt <= 0.
  - {carry, acc} <= acc + frac_q.
  - extra <= carry.
  - sample_tick <= 1.
  - mid_tick <= (sub == osr_q>>1).
  - If sub == osr_q: sub <= 0 and bit_tick <= 1. Otherwise sub <= sub+1 and bit_tick <= 0.
- On a non-terminal cycle: cnt <= cnt+1 and all outputs are 0 next cycle.
- Latency:
  - Outputs are registered, so a tick appears the cycle after the terminal cycle.
  - With continuous en after a load/resync at cycle L, the first sample_tick is in cycle L+dvsr_q+2.
- Period:
  - The first period after load/resync is dvsr_q+1 cycles.
  - Each later period is dvsr_q+1+extra cycles.
  - Over every 2^FRAC_W consecutive sample ticks, exactly frac_q periods are extended by one cycle.
- Tick relationships:
  - bit_tick and mid_tick are only ever high together with sample_tick.
  - bit_tick fires once per osr_q+1 sample ticks, the first on the (osr_q+1)th sample tick after load/resync.
  - mid_tick fires once per osr_q+1 sample ticks, on the ((osr_q>>1)+1)th sample tick after load/resync.
  - If osr_q=0: every sample tick is both a bit_tick and a mid_tick.
- dvsr_q=0 with frac_q=0: sample_tick is high every cycle while en=1 (after the first).
- Outputs are never X after reset; all outputs are single-cycle pulses except in the dvsr_q=0 case.

Test Plan:
1. Reset defaults: hold reset_n=0 for 3 cycles, release, en=1 -> first sample_tick exactly 651 cycles after the first enabled cycle; subsequent spacing 651; bit_tick every 16th sample_tick; mid_tick on the 8th, 24th, ... sample_tick.
2. Fractional divisor: load dvsr_int=9, dvsr_frac=4, osr=3, en=1 -> spacing pattern 10,10,10,11 repeating; 16 sample ticks span exactly 164 cycles; bit_tick on every 4th sample_tick, mid_tick on the 2nd of each group.
3. Enable gating: dvsr_int=3, frac=0; drop en for 5 cycles when cnt=2 -> no ticks during the gap; next sample_tick arrives 2 enabled cycles after en returns (count resumes from 2, not 0).
4. Resync mid-bit: osr=15, dvsr_int=2; pulse resync after 7 sample ticks -> sub restarts; the next bit_tick arrives after 16 further sample ticks; shadow config is unchanged.
5. Simultaneous load+resync+terminal: assert load and resync in the same cycle that cnt==dvsr_q -> no tick is emitted, new config is captured, first tick at L+new_dvsr+2.
6. Mid-operation reset and boundary: dvsr_int=0, frac=0, osr=0 -> sample_tick, bit_tick and mid_tick high every cycle; assert reset_n=0 for one cycle -> all outputs 0 the next cycle and defaults restored.

Source files
------------

// File: rtl/baud_tick_generator.sv
// Fractional baud/oversample tick generator: a fractional-N sample divider
// feeding a sub-counter that derives bit-rate and mid-bit ticks.
module baud_tick_generator #(
  parameter int unsigned DVSR_W     = 16,
  parameter int unsigned FRAC_W     = 4,
  parameter int unsigned OSR_W      = 5,
  parameter int unsigned RESET_DVSR = 650,
  parameter int unsigned RESET_FRAC = 0,
  parameter int unsigned RESET_OSR  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic              resync,
  input  logic [DVSR_W-1:0] dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  input  logic [OSR_W-1:0]  osr,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  logic [DVSR_W-1:0] dvsr_q;
  logic [FRAC_W-1:0] frac_q;
  logic [OSR_W-1:0]  osr_q;

  logic [DVSR_W-1:0] cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [OSR_W-1:0]  sub;

  logic [DVSR_W:0]   term_val;
  logic              terminal;
  logic [FRAC_W:0]   acc_sum;

  // One extra bit so an all-ones divisor stretched by 'extra' cannot wrap.
  always_comb begin
    term_val = {1'b0, dvsr_q} + {{DVSR_W{1'b0}}, extra};
    terminal = ({1'b0, cnt} == term_val);
    acc_sum  = {1'b0, acc} + {1'b0, frac_q};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dvsr_q      <= DVSR_W'(RESET_DVSR);
      frac_q      <= FRAC_W'(RESET_FRAC);
      osr_q       <= OSR_W'(RESET_OSR);
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      sub         <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
    end else if (load) begin
      dvsr_q      <= dvsr_int;
      frac_q      <= dvsr_frac;
      osr_q       <= osr;
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      sub         <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
    end else if (resync) begin
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      sub         <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        cnt         <= '0;
        acc         <= acc_sum[FRAC_W-1:0];
        extra       <= acc_sum[FRAC_W];
        sample_tick <= 1'b1;
        mid_tick    <= (sub == (osr_q >> 1));
        if (sub == osr_q) begin
          sub      <= '0;
          bit_tick <= 1'b1;
        end else begin
          sub      <= sub + OSR_W'(1);
          bit_tick <= 1'b0;
        end
      end else begin
        cnt         <= cnt + DVSR_W'(1);
        sample_tick <= 1'b0;
        bit_tick    <= 1'b0;
        mid_tick    <= 1'b0;
      end
    end else begin
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator: closed-form tick-time model checked
// every cycle, plus hand-computed spacing and tick-position expectations.
module tb_baud_tick_generator;

  localparam int unsigned DVSR_W = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OSR_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic              load;
  logic              resync;
  logic [DVSR_W-1:0] dvsr_int;
  logic [FRAC_W-1:0] dvsr_frac;
  logic [OSR_W-1:0]  osr;
  logic              sample_tick;
  logic              bit_tick;
  logic              mid_tick;

  int checks = 0;
  int errors = 0;

  baud_tick_generator #(
    .DVSR_W(DVSR_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W),
    .RESET_DVSR(650), .RESET_FRAC(0), .RESET_OSR(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .resync(resync),
    .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac), .osr(osr),
    .sample_tick(sample_tick), .bit_tick(bit_tick), .mid_tick(mid_tick)
  );

  always #5 clk = ~clk;

  // Model: tick k (0-based) after a restart falls on enabled edge
  // (k+1)*(d+1) + floor(k*f/2^FRAC_W); bit/mid follow from k mod (osr+1).
  longint md = 650, mf = 0, mo = 15;
  longint me = 0, mk = 0;
  bit     model_valid = 1'b0;
  logic   exp_s = 1'b0, exp_b = 1'b0, exp_m = 1'b0;

  always @(posedge clk) begin
    exp_s = 1'b0; exp_b = 1'b0; exp_m = 1'b0;
    if (!reset_n) begin
      md = 650; mf = 0; mo = 15; me = 0; mk = 0;
      model_valid = 1'b1;
    end else if (load) begin
      md = longint'(dvsr_int); mf = longint'(dvsr_frac); mo = longint'(osr);
      me = 0; mk = 0;
    end else if (resync) begin
      me = 0; mk = 0;
    end else if (en) begin
      me++;
      if (me == (mk + 1) * (md + 1) + (mk * mf) / (2 ** FRAC_W)) begin
        exp_s = 1'b1;
        exp_b = ((mk % (mo + 1)) == mo);
        exp_m = ((mk % (mo + 1)) == (mo >> 1));
        mk++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if ({sample_tick, bit_tick, mid_tick} !== {exp_s, exp_b, exp_m}) begin
        errors++;
        $display("FAIL model t=%0t: {sample,bit,mid} actual=%b%b%b required=%b%b%b",
                 $time, sample_tick, bit_tick, mid_tick, exp_s, exp_b, exp_m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Edges until sample_tick is seen (bounded); 0 on timeout.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < limit);
    if (!sample_tick) begin
      checks++;
      errors++;
      $display("FAIL timeout: no sample_tick within %0d cycles", limit);
      n = 0;
    end
  endtask

  task automatic do_load(input int d, input int f, input int o);
    dvsr_int = DVSR_W'(d); dvsr_frac = FRAC_W'(f); osr = OSR_W'(o);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  int n, total;

  initial begin
    reset_n = 1'b0; en = 1'b0; load = 1'b0; resync = 1'b0;
    dvsr_int = '0; dvsr_frac = '0; osr = '0;
    @(negedge clk);

    // 1: reset defaults
    repeat (3) step();
    chk("reset_outputs", {sample_tick, bit_tick, mid_tick}, 0);
    reset_n = 1'b1; en = 1'b1;
    wait_tick(2000, n);
    chk("t1_first_tick", n, 651);
    for (int i = 2; i <= 16; i++) begin
      wait_tick(2000, n);
      if (i == 2) chk("t1_spacing", n, 651);
      if (i == 8) chk("t1_mid_on_8th", mid_tick, 1);
      if (i == 15) chk("t1_no_bit_on_15th", bit_tick, 0);
    end
    chk("t1_bit_on_16th", bit_tick, 1);

    // 2: fractional divisor 9 + 4/16, osr 3
    do_load(9, 4, 3);
    wait_tick(100, n);
    chk("t2_first_tick", n, 10);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(100, n);
      total += n;
      if (i < 8) chk("t2_spacing", n, (i % 4 == 3) ? 11 : 10);
      if (i == 2) chk("t2_bit_on_4th", bit_tick, 1);
      if (i == 4) chk("t2_mid_on_6th", mid_tick, 1);
    end
    chk("t2_span16", total, 164);

    // 3: enable gating with cnt parked at 2
    do_load(3, 0, 0);
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_gap_quiet", sample_tick, 0);
    end
    en = 1'b1;
    wait_tick(20, n);
    chk("t3_resume", n, 2);

    // 4: resync mid-bit
    do_load(2, 0, 15);
    for (int i = 0; i < 7; i++) wait_tick(20, n);
    resync = 1'b1;
    step();
    resync = 1'b0;
    wait_tick(20, n);
    chk("t4_config_kept", n, 3);
    total = 1;
    while (!bit_tick && total < 40) begin
      wait_tick(20, n);
      total++;
    end
    chk("t4_bit_after_resync", total, 16);

    // 5: load+resync on a terminal cycle
    wait_tick(20, n);
    step(); step();
    resync = 1'b1;
    do_load(5, 0, 1);
    resync = 1'b0;
    chk("t5_suppressed", sample_tick, 0);
    wait_tick(20, n);
    chk("t5_first_tick", n, 6);

    // 6: divide-by-one, then mid-operation reset
    do_load(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_all_high", {sample_tick, bit_tick, mid_tick}, 7);
    end
    reset_n = 1'b0;
    step();
    chk("t6_reset_clears", {sample_tick, bit_tick, mid_tick}, 0);
    reset_n = 1'b1;
    wait_tick(2000, n);
    chk("t6_defaults_restored", n, 651);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
